alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Hardware initiator for the 8-bit ALU's pin-level interface. It accepts tagged ALU commands on a valid/ready stream and buffers them in a small FIFO. It drives a, b and selection to the ALU, waits a fixed latency, then captures result and carry_out. Each completed operation is returned on a valid/ready response stream carrying the original tag. It sits between a command source (CPU-side or test sequencer) and the ALU, and is the driving end of the ALU's operand/selection/result interface.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
ALU_LATENCY, 1, cycles from ALU inputs updating to result/carry_out sampling (>=1)
TAG_W, 4, width of command/response tag

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_sel  input  4  ALU selection code
cmd_tag  input  TAG_W  command tag
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_selection  output  4  to ALU selection
alu_result  input  8  from ALU result
alu_carry_out  input  1  from ALU carry_out
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  captured result
rsp_carry  output  1  captured carry_out
rsp_tag  output  TAG_W  tag of completed command
busy  output  1  high when state != IDLE or FIFO non-empty
op_count  output  16  completed responses, wraps 16'hFFFF->0

Behaviour:
- One clock (clock); reset is asynchronous and active-high. Assertion immediately clears all state regardless of clock.
- Reset values: cmd_ready=1, alu_a=0, alu_b=0, alu_selection=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_tag=0, busy=0, op_count=0. FIFO is empty, state is IDLE, and the wait counter is 0.
- Reset mid-operation: in-flight op and all buffered commands are discarded. No response is produced for them.
- Push: on a posedge with cmd_valid && cmd_ready. cmd_ready is purely !full. A push attempt while full is refused even if a pop occurs on the same edge. There is no bypass; a push into an empty FIFO is first visible to the FSM on the next cycle.
- FIFO: circular buffer with read/write pointers wrapping at DEPTH, plus an occupancy counter. Simultaneous push+pop when not full leaves the count unchanged.
- FSM states: IDLE, WAIT, RESP.
- IDLE, FIFO non-empty: pop the head and register alu_a/alu_b/alu_selection plus an internal tag. Load the counter with ALU_LATENCY-1 and go to WAIT.
- IDLE, FIFO empty: stay in IDLE.
- WAIT, counter != 0: decrement the counter.
- WAIT, counter == 0: capture alu_result->rsp_result, alu_carry_out->rsp_carry and tag->rsp_tag. Set rsp_valid=1 and go to RESP.
- RESP, no handshake: rsp_valid and all rsp_* fields stay stable until rsp_valid && rsp_ready.
- RESP, handshake: clear rsp_valid and increment op_count. If the FIFO is non-empty on that same edge, pop and issue immediately (go to WAIT, as from IDLE); otherwise go to IDLE.
- alu_* outputs hold the last issued values between operations and never return to 0 except on reset.
- Latency: command accepted at edge E0 -> alu_* update at E1 -> result sampled at E(1+ALU_LATENCY) -> rsp_valid high after that edge.
- Sustained throughput with rsp_ready tied high is one op per ALU_LATENCY+1 cycles.
- Ordering: responses are strictly in command order. Tags are pass-through only, with no uniqueness check.
- Arithmetic: op_count is a 16-bit modulo counter. rsp_result and rsp_carry are copied verbatim, with no interpretation of the selection code.

Test Plan:
- Single op, ALU_LATENCY=1, bench ALU model with sel 0 = add: cmd a=8'h0F, b=8'h01, sel=0, tag=3 at E0. Expect alu_a=8'h0F at E1 and rsp_valid after E2 with rsp_result=8'h10, rsp_carry=0, rsp_tag=3; op_count=1 after handshake.
- Carry and backpressure: a=8'hFF, b=8'h01, sel=0, rsp_ready held low for 5 cycles. Expect rsp_result=8'h00, rsp_carry=1, with rsp_* stable throughout the stall and rsp_valid dropping the cycle after the handshake.
- FIFO full: rsp_ready=0, push 6 commands (tags 0-5) back-to-back. Expect cmd_ready low once the FIFO holds 4 with one in flight. After releasing rsp_ready, responses return as tags 0-5 in order and op_count=6.
- Simultaneous events: hold rsp_ready=1 with the FIFO non-empty and ALU_LATENCY=3. Expect a new alu_* issue on the same edge as each response handshake, with responses spaced 4 cycles apart.
- Reset mid-operation: assert reset asynchronously during WAIT with 2 commands queued. Expect all outputs at reset values immediately and no stale response after release. A new command then completes normally with op_count=1.
- op_count wrap: preload via 65536 ops (or force) and expect op_count to go 16'hFFFF->16'h0000.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU pin / response bundle for alu_cmd_issuer.
// master: the issuer (accepts commands, drives the ALU pins, produces responses).
// slave:  the environment (command source, ALU, response consumer).
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
) ();
  // command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  // ALU pin-level interface
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_selection;
  logic [7:0]       alu_result;
  logic             alu_carry_out;
  // response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_selection,
    input  alu_result, alu_carry_out,
    output rsp_valid, rsp_result, rsp_carry, rsp_tag,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_selection,
    output alu_result, alu_carry_out,
    input  rsp_valid, rsp_result, rsp_carry, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Purpose: queues tagged ALU commands, drives them onto the ALU pins one at a time,
//          samples result/carry after ALU_LATENCY cycles and returns them with the tag.
// Latency: accept at E0 -> alu_* at E1 -> sampled at E(1+ALU_LATENCY); cmd_ready = !full.
// Ports: clock, reset (async, active-high), bus (master modport: cmd/alu/rsp groups),
//        busy (FSM active or FIFO non-empty), op_count (16-bit wrapping response count).
module alu_cmd_issuer #(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_cmd_issuer_if.master     bus,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // command FIFO
  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  // issue/response FSM
  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      op_count_q;
  logic             rsp_hs;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  // Full refuses a push even when a pop happens on the same edge.
  assign push   = bus.cmd_valid && !full;
  assign head   = mem[rd_ptr];
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
  // Pop happens on the same edge as issue: from IDLE, or straight out of RESP on handshake.
  assign pop    = !empty && ((state == IDLE) || ((state == RESP) && rsp_hs));

  assign bus.cmd_ready = !full;
  assign busy          = (state != IDLE) || !empty;
  assign op_count      = op_count_q;

  // storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel, bus.cmd_tag};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      tag_q             <= '0;
      op_count_q        <= '0;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_selection <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_result    <= '0;
      bus.rsp_carry     <= 1'b0;
      bus.rsp_tag       <= '0;
    end else begin
      case (state)
        IDLE: ;  // issue handled below
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_carry  <= bus.alu_carry_out;
            bus.rsp_tag    <= tag_q;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            bus.rsp_valid <= 1'b0;
            op_count_q    <= op_count_q + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Issue overrides the IDLE fallback above so a queued command goes out on
      // the same edge as the response handshake.
      if (pop) begin
        bus.alu_a         <= head.a;
        bus.alu_b         <= head.b;
        bus.alu_selection <= head.sel;
        tag_q             <= head.tag;
        wait_cnt          <= CW'(ALU_LATENCY - 1);
        state             <= WAIT;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: dut1 runs ALU_LATENCY=1, dut3 runs ALU_LATENCY=3.
// A small ALU model (sel 0 add, sel 1 subtract with borrow as carry, else xor) answers both.
module tb_alu_cmd_issuer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy1, busy3;
  logic [15:0] op_count1, op_count3;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_cmd_issuer_if #(.TAG_W(4)) if1 ();
  alu_cmd_issuer_if #(.TAG_W(4)) if3 ();

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {if1.alu_carry_out, if1.alu_result} = alu_model(if1.alu_a, if1.alu_b, if1.alu_selection);
  assign {if3.alu_carry_out, if3.alu_result} = alu_model(if3.alu_a, if3.alu_b, if3.alu_selection);

  alu_cmd_issuer #(.DEPTH(4), .ALU_LATENCY(1), .TAG_W(4)) dut1 (
    .clock(clock), .reset(reset), .bus(if1), .busy(busy1), .op_count(op_count1));
  alu_cmd_issuer #(.DEPTH(4), .ALU_LATENCY(3), .TAG_W(4)) dut3 (
    .clock(clock), .reset(reset), .bus(if3), .busy(busy3), .op_count(op_count3));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [51:0] want;
    want = {1'b1, 51'd0};
    reset = 1'b1;
    #1;  // before any clock edge: reset must act asynchronously
    n_checks++;
    if ({if1.cmd_ready, if1.alu_a, if1.alu_b, if1.alu_selection, if1.rsp_valid, if1.rsp_result,
         if1.rsp_carry, if1.rsp_tag, busy1, op_count1} !== want) begin
      n_fail++;
      $display("FAIL reset_dut1: ready=%b a=%h b=%h sel=%h v=%b r=%h c=%b t=%h busy=%b cnt=%h, want ready=1 rest 0",
               if1.cmd_ready, if1.alu_a, if1.alu_b, if1.alu_selection, if1.rsp_valid,
               if1.rsp_result, if1.rsp_carry, if1.rsp_tag, busy1, op_count1);
    end
    n_checks++;
    if ({if3.cmd_ready, if3.alu_a, if3.alu_b, if3.alu_selection, if3.rsp_valid, if3.rsp_result,
         if3.rsp_carry, if3.rsp_tag, busy3, op_count3} !== want) begin
      n_fail++;
      $display("FAIL reset_dut3: ready=%b a=%h v=%b busy=%b cnt=%h, want ready=1 rest 0",
               if3.cmd_ready, if3.alu_a, if3.rsp_valid, busy3, op_count3);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    if1.rsp_ready = 1'b0;
    if1.cmd_a = 8'h0F; if1.cmd_b = 8'h01; if1.cmd_sel = 4'd0; if1.cmd_tag = 4'd3;
    if1.cmd_valid = 1'b1;
    tick();  // E0: push
    if1.cmd_valid = 1'b0;
    n_checks++;
    if ({if1.alu_a, busy1} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL single_no_bypass: alu_a=%h busy=%b, want alu_a=00 busy=1", if1.alu_a, busy1);
    end
    tick();  // E1: issue
    n_checks++;
    if ({if1.alu_a, if1.alu_b, if1.alu_selection, if1.rsp_valid} !== {8'h0F, 8'h01, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_issue: a=%h b=%h sel=%h v=%b, want a=0f b=01 sel=0 v=0",
               if1.alu_a, if1.alu_b, if1.alu_selection, if1.rsp_valid);
    end
    tick();  // E2: sample
    n_checks++;
    if ({if1.rsp_valid, if1.rsp_result, if1.rsp_carry, if1.rsp_tag} !== {1'b1, 8'h10, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL single_rsp: v=%b r=%h c=%b t=%h, want v=1 r=10 c=0 t=3",
               if1.rsp_valid, if1.rsp_result, if1.rsp_carry, if1.rsp_tag);
    end
    if1.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({if1.rsp_valid, op_count1, busy1} !== {1'b0, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: v=%b cnt=%h busy=%b, want v=0 cnt=0001 busy=0",
               if1.rsp_valid, op_count1, busy1);
    end
    if1.rsp_ready = 1'b0;
  endtask

  task automatic test_carry_backpressure();
    logic got;
    int   unstable;
    if1.cmd_a = 8'hFF; if1.cmd_b = 8'h01; if1.cmd_sel = 4'd0; if1.cmd_tag = 4'd7;
    if1.cmd_valid = 1'b1;
    tick();
    if1.cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (if1.rsp_valid) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || {if1.rsp_result, if1.rsp_carry, if1.rsp_tag} !== {8'h00, 1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL carry_rsp: got=%b r=%h c=%b t=%h, want got=1 r=00 c=1 t=7",
               got, if1.rsp_result, if1.rsp_carry, if1.rsp_tag);
    end
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({if1.rsp_valid, if1.rsp_result, if1.rsp_carry, if1.rsp_tag} !== {1'b1, 8'h00, 1'b1, 4'd7})
        unstable++;
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles, want 0", unstable);
    end
    if1.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({if1.rsp_valid, op_count1, if1.alu_a} !== {1'b0, 16'd2, 8'hFF}) begin
      n_fail++;
      $display("FAIL carry_done: v=%b cnt=%h alu_a=%h, want v=0 cnt=0002 alu_a=ff",
               if1.rsp_valid, op_count1, if1.alu_a);
    end
    if1.rsp_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    int         acc;
    int         n_rsp;
    int         ready_leak;
    logic       will;
    logic       pending;
    logic [3:0] tags [6];
    logic [7:0] res [6];
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    if1.rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 20 && acc < 5; k++) begin
      if1.cmd_a = 8'(acc * 17); if1.cmd_b = 8'h01; if1.cmd_sel = 4'd0; if1.cmd_tag = 4'(acc);
      if1.cmd_valid = 1'b1;
      will = if1.cmd_ready;
      tick();
      if (will) acc++;
    end
    n_checks++;
    if (acc !== 5 || if1.cmd_ready !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready: accepted=%0d ready=%b busy=%b, want 5 ready=0 busy=1",
               acc, if1.cmd_ready, busy1);
    end
    // tag 5 offered while full: must be refused for as long as the response stalls
    if1.cmd_a = 8'(5 * 17); if1.cmd_tag = 4'd5;
    ready_leak = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (if1.cmd_ready !== 1'b0) ready_leak++;
    end
    n_checks++;
    if (ready_leak !== 0 || if1.rsp_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL full_hold: ready_high=%0d head_tag=%h, want 0 and 0", ready_leak, if1.rsp_tag);
    end
    if1.rsp_ready = 1'b1;
    n_rsp = 0;
    pending = 1'b1;
    for (int k = 0; k < 80 && n_rsp < 6; k++) begin
      if1.cmd_valid = pending;
      will = pending && if1.cmd_ready;
      if (if1.rsp_valid) begin
        tags[n_rsp] = if1.rsp_tag;
        res[n_rsp]  = if1.rsp_result;
        n_rsp++;
      end
      tick();
      if (will) pending = 1'b0;
    end
    if1.cmd_valid = 1'b0;
    if1.rsp_ready = 1'b0;
    n_checks++;
    if (n_rsp !== 6) begin
      n_fail++;
      $display("FAIL full_count: %0d responses, want 6", n_rsp);
    end
    for (int i = 0; i < n_rsp; i++) begin
      n_checks++;
      if ({tags[i], res[i]} !== {4'(i), 8'(i * 17 + 1)}) begin
        n_fail++;
        $display("FAIL full_order[%0d]: tag=%h res=%h, want tag=%h res=%h",
                 i, tags[i], res[i], 4'(i), 8'(i * 17 + 1));
      end
    end
    n_checks++;
    if (op_count1 !== 16'd6) begin
      n_fail++;
      $display("FAIL full_opcount: %h, want 0006", op_count1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ca [3];
    logic [7:0] cb [3];
    logic [3:0] cs [3];
    logic [8:0] want [3];
    logic [8:0] got_rc [3];
    logic [3:0] got_tag [3];
    int         hs_edge [3];
    int         iss_edge [3];
    int         ci, ri, ii;
    logic       will;
    logic [7:0] prev_a;
    ca[0] = 8'h01; cb[0] = 8'h02; cs[0] = 4'd0; want[0] = 9'h003;
    ca[1] = 8'h20; cb[1] = 8'h05; cs[1] = 4'd1; want[1] = 9'h01B;
    ca[2] = 8'h03; cb[2] = 8'h04; cs[2] = 4'd1; want[2] = 9'h1FF;
    ci = 0; ri = 0; ii = 0;
    prev_a = if3.alu_a;
    if3.rsp_ready = 1'b1;
    for (int k = 0; k < 60 && ri < 3; k++) begin
      if (ci < 3) begin
        if3.cmd_a = ca[ci]; if3.cmd_b = cb[ci]; if3.cmd_sel = cs[ci]; if3.cmd_tag = 4'(9 + ci);
        if3.cmd_valid = 1'b1;
      end else begin
        if3.cmd_valid = 1'b0;
      end
      will = if3.cmd_valid && if3.cmd_ready;
      if (if3.rsp_valid) begin
        hs_edge[ri] = cyc + 1;
        got_rc[ri]  = {if3.rsp_carry, if3.rsp_result};
        got_tag[ri] = if3.rsp_tag;
        ri++;
      end
      tick();
      if (will) ci++;
      if (if3.alu_a !== prev_a && ii < 3) begin
        iss_edge[ii] = cyc;
        prev_a = if3.alu_a;
        ii++;
      end
    end
    if3.cmd_valid = 1'b0;
    n_checks++;
    if (ri !== 3 || ii !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: responses=%0d issues=%0d, want 3 and 3", ri, ii);
    end else begin
      n_checks++;
      if (iss_edge[1] !== hs_edge[0] || iss_edge[2] !== hs_edge[1]) begin
        n_fail++;
        $display("FAIL b2b_same_edge: issue edges %0d,%0d handshake edges %0d,%0d, want equal",
                 iss_edge[1], iss_edge[2], hs_edge[0], hs_edge[1]);
      end
      n_checks++;
      if (hs_edge[0] - iss_edge[0] !== 4 || hs_edge[1] - hs_edge[0] !== 4 ||
          hs_edge[2] - hs_edge[1] !== 4) begin
        n_fail++;
        $display("FAIL b2b_spacing: gaps %0d,%0d,%0d, want 4,4,4", hs_edge[0] - iss_edge[0],
                 hs_edge[1] - hs_edge[0], hs_edge[2] - hs_edge[1]);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({got_tag[i], got_rc[i]} !== {4'(9 + i), want[i]}) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: tag=%h carry_res=%h, want tag=%h carry_res=%h",
                   i, got_tag[i], got_rc[i], 4'(9 + i), want[i]);
        end
      end
    end
    if3.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int   stale;
    logic got;
    if3.rsp_ready = 1'b0;
    if3.cmd_b = 8'h00; if3.cmd_sel = 4'd0;
    if3.cmd_a = 8'h44; if3.cmd_tag = 4'd1; if3.cmd_valid = 1'b1;
    tick();
    if3.cmd_a = 8'h55; if3.cmd_tag = 4'd2;
    tick();
    if3.cmd_a = 8'h66; if3.cmd_tag = 4'd3;
    tick();
    if3.cmd_valid = 1'b0;
    n_checks++;
    if ({if3.alu_a, busy3, if3.rsp_valid} !== {8'h44, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_pre: alu_a=%h busy=%b v=%b, want 44 1 0", if3.alu_a, busy3, if3.rsp_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({if3.cmd_ready, if3.alu_a, if3.alu_b, if3.alu_selection, if3.rsp_valid, if3.rsp_result,
         if3.rsp_carry, if3.rsp_tag, busy3, op_count3} !== {1'b1, 51'd0}) begin
      n_fail++;
      $display("FAIL midrst_async: ready=%b a=%h v=%b r=%h t=%h busy=%b cnt=%h, want ready=1 rest 0",
               if3.cmd_ready, if3.alu_a, if3.rsp_valid, if3.rsp_result, if3.rsp_tag, busy3, op_count3);
    end
    #2;
    reset = 1'b0;
    if3.rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if3.rsp_valid !== 1'b0 || busy3 !== 1'b0) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL midrst_stale: %0d cycles with response or busy, want 0", stale);
    end
    if3.cmd_a = 8'h21; if3.cmd_b = 8'h12; if3.cmd_sel = 4'd0; if3.cmd_tag = 4'hC;
    if3.cmd_valid = 1'b1;
    tick();
    if3.cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (if3.rsp_valid) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || {if3.rsp_result, if3.rsp_carry, if3.rsp_tag} !== {8'h33, 1'b0, 4'hC}) begin
      n_fail++;
      $display("FAIL midrst_new: got=%b r=%h c=%b t=%h, want got=1 r=33 c=0 t=c",
               got, if3.rsp_result, if3.rsp_carry, if3.rsp_tag);
    end
    tick();
    n_checks++;
    if (op_count3 !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_opcount: %h, want 0001", op_count3);
    end
    if3.rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic        got;
    logic [15:0] want [2];
    want[0] = 16'hFFFF;
    want[1] = 16'h0000;
    force dut1.op_count_q = 16'hFFFE;
    tick();
    release dut1.op_count_q;
    tick();
    n_checks++;
    if (op_count1 !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap_preload: %h, want fffe", op_count1);
    end
    if1.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if1.cmd_a = 8'h01; if1.cmd_b = 8'h01; if1.cmd_sel = 4'd2; if1.cmd_tag = 4'(i);
      if1.cmd_valid = 1'b1;
      tick();
      if1.cmd_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (if1.rsp_valid) got = 1'b1;
        else tick();
      end
      tick();
      n_checks++;
      if (!got || op_count1 !== want[i]) begin
        n_fail++;
        $display("FAIL wrap_step[%0d]: got=%b cnt=%h, want got=1 cnt=%h", i, got, op_count1, want[i]);
      end
    end
    if1.rsp_ready = 1'b0;
  endtask

  initial begin
    if1.cmd_valid = 1'b0; if1.cmd_a = '0; if1.cmd_b = '0; if1.cmd_sel = '0; if1.cmd_tag = '0;
    if1.rsp_ready = 1'b0;
    if3.cmd_valid = 1'b0; if3.cmd_a = '0; if3.cmd_b = '0; if3.cmd_sel = '0; if3.cmd_tag = '0;
    if3.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_carry_backpressure();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
